iterative_shift_unit: RTL and testbench

- Multi-cycle serial shifter for the EX stage. Executes RV32I SLL/SRL/SRA (register and immediate forms) by shifting one bit position per clock.
- Input is the operand and shift amount from the ID/EX register.
- Output is the shifted result, which goes to the EX/MEM result mux.
- `busy` is consumed by the hazard unit to stall IF/ID/EX while a shift is in flight.

---
 rtl/iterative_shift_unit.sv | 94 +++++++++
 tb/tb_iterative_shift_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_shift_unit.sv
// Serial RV32I shifter for the EX stage: SLL/SRL/SRA one bit per clock.
// busy stalls the front of the pipe while a shift is in flight; done pulses
// for one cycle when result carries the freshly shifted value.
module iterative_shift_unit #(
  parameter int N       = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [N-1:0]       a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [N-1:0]       result
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t             state;
  logic [N-1:0]       data_reg;
  logic [SHAMT_W-1:0] cnt;
  logic [1:0]         op_reg;
  logic               accept;

  // One-position shift; the reserved op leaves the operand untouched.
  function automatic logic [N-1:0] shift_one(input logic [N-1:0] d,
                                             input logic [1:0]   o);
    logic signed [N-1:0] sd;
    logic [N-1:0]        r;
    sd = signed'(d);
    case (o)
      OP_SLL:  r = {d[N-2:0], 1'b0};
      OP_SRL:  r = {1'b0, d[N-1:1]};
      OP_SRA:  r = unsigned'(sd >>> 1);
      default: r = d;
    endcase
    return r;
  endfunction

  // A new operation is only taken when no shift is in progress.
  assign accept = start && (state != SHIFT);

  // Control FSM plus datapath: rst beats flush, flush beats start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_reg <= '0;
      cnt      <= '0;
      op_reg   <= '0;
      result   <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            data_reg <= a;
            op_reg   <= op;
            cnt      <= (op == 2'b11) ? '0 : shamt;
            state    <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            cnt      <= cnt - 1'b1;
            data_reg <= shift_one(data_reg, op_reg);
          end else begin
            result <= data_reg;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status flags are pure decodes of the registered state.
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Directed bench for iterative_shift_unit: latency, results, flush, reset.
module tb_iterative_shift_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  iterative_shift_unit #(.N(32), .SHAMT_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .shamt  (shamt),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle before looking at outputs or changing inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch an op, drop start, and wait (bounded) for done; counts busy cycles.
  task automatic launch_wait(input logic [1:0] o, input logic [31:0] av,
                             input logic [4:0] sh, output int bcnt,
                             output logic [31:0] res, output bit ok);
    start = 1'b1; op = o; a = av; shamt = sh;
    tick();
    start = 1'b0;
    ok = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 64; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) bcnt++;
      tick();
    end
    res = result;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; shamt = '0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b result=%h, required 0 0 00000000",
               busy, done, result);
    end
  endtask

  task automatic test_sra();
    int  bcnt;
    bit  ok;
    bit  res_zero;
    start = 1'b1; op = 2'b10; a = 32'h8000_0000; shamt = 5'd4;
    tick();
    start = 1'b0;
    bcnt = 0; ok = 1'b0; res_zero = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) bcnt++;
      if (result !== 32'h0) res_zero = 1'b0;
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL sra_timeout: done never seen, required within 64 cycles");
    end
    checks++;
    if (bcnt != 5) begin
      errors++;
      $display("FAIL sra_busy_cycles: got %0d, required 5", bcnt);
    end
    checks++;
    if (!res_zero) begin
      errors++;
      $display("FAIL sra_result_before_done: result changed early, required 00000000");
    end
    checks++;
    if (result !== 32'hF800_0000) begin
      errors++;
      $display("FAIL sra_result: got %h, required f8000000", result);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 32'hF800_0000) begin
      errors++;
      $display("FAIL sra_after_done: done=%b busy=%b result=%h, required 0 0 f8000000",
               done, busy, result);
    end
  endtask

  task automatic test_full_width();
    int          bcnt;
    logic [31:0] res;
    bit          ok;
    launch_wait(2'b00, 32'h0000_0001, 5'd31, bcnt, res, ok);
    checks++;
    if (!ok || res !== 32'h8000_0000 || bcnt != 32) begin
      errors++;
      $display("FAIL sll31: ok=%0d result=%h busy=%0d, required 1 80000000 32", ok, res, bcnt);
    end
    tick();
    launch_wait(2'b01, 32'h8000_0000, 5'd31, bcnt, res, ok);
    checks++;
    if (!ok || res !== 32'h0000_0001 || bcnt != 32) begin
      errors++;
      $display("FAIL srl31: ok=%0d result=%h busy=%0d, required 1 00000001 32", ok, res, bcnt);
    end
    tick();
    launch_wait(2'b10, 32'hFFFF_FF00, 5'd31, bcnt, res, ok);
    checks++;
    if (!ok || res !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL sra31_neg: ok=%0d result=%h, required 1 ffffffff", ok, res);
    end
    tick();
    launch_wait(2'b10, 32'h7000_0000, 5'd4, bcnt, res, ok);
    checks++;
    if (!ok || res !== 32'h0700_0000) begin
      errors++;
      $display("FAIL sra_pos: ok=%0d result=%h, required 1 07000000", ok, res);
    end
    tick();
  endtask

  task automatic test_zero_and_reserved();
    int          bcnt;
    logic [31:0] res;
    bit          ok;
    launch_wait(2'b00, 32'h1234_5678, 5'd0, bcnt, res, ok);
    checks++;
    if (!ok || res !== 32'h1234_5678 || bcnt != 1) begin
      errors++;
      $display("FAIL sll0: ok=%0d result=%h busy=%0d, required 1 12345678 1", ok, res, bcnt);
    end
    tick();
    launch_wait(2'b11, 32'hDEAD_BEEF, 5'd7, bcnt, res, ok);
    checks++;
    if (!ok || res !== 32'hDEAD_BEEF || bcnt != 1) begin
      errors++;
      $display("FAIL reserved_op: ok=%0d result=%h busy=%0d, required 1 deadbeef 1", ok, res, bcnt);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int  bcnt;
    bit  ok;
    // First op SRL 0xF0 by 4; start stays high with the second op's operands.
    start = 1'b1; op = 2'b01; a = 32'h0000_00F0; shamt = 5'd4;
    tick();
    op = 2'b00; a = 32'h0000_0001; shamt = 5'd3;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok || result !== 32'h0000_000F) begin
      errors++;
      $display("FAIL b2b_first: ok=%0d result=%h, required 1 0000000f", ok, result);
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_idle: busy=%b done=%b, required 1 0", busy, done);
    end
    bcnt = 0; ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) bcnt++;
      tick();
    end
    checks++;
    if (!ok || result !== 32'h0000_0008 || bcnt != 4) begin
      errors++;
      $display("FAIL b2b_second: ok=%0d result=%h busy=%0d, required 1 00000008 4",
               ok, result, bcnt);
    end
    tick();
  endtask

  task automatic test_flush();
    bit saw;
    start = 1'b1; op = 2'b00; a = 32'h0000_00FF; shamt = 5'd20;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre_busy: busy=%b, required 1", busy);
    end
    flush = 1'b1; start = 1'b1; op = 2'b00; a = 32'h1; shamt = 5'd0;
    tick();
    flush = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0000_0008) begin
      errors++;
      $display("FAIL flush_abort: busy=%b done=%b result=%h, required 0 0 00000008",
               busy, done, result);
    end
    saw = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (done || busy) saw = 1'b1;
      tick();
    end
    checks++;
    if (saw || result !== 32'h0000_0008) begin
      errors++;
      $display("FAIL flush_quiet: activity=%0d result=%h, required 0 00000008", saw, result);
    end
  endtask

  task automatic test_busy_and_reset();
    int bcnt;
    bit ok;
    bit saw;
    start = 1'b1; op = 2'b01; a = 32'hA5A5_0000; shamt = 5'd8;
    tick();
    bcnt = 1;
    op = 2'b00; a = 32'hFFFF_FFFF; shamt = 5'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy) bcnt++;
    end
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
      if (busy) bcnt++;
    end
    checks++;
    if (!ok || result !== 32'h00A5_A500 || bcnt != 9) begin
      errors++;
      $display("FAIL start_while_busy: ok=%0d result=%h busy=%0d, required 1 00a5a500 9",
               ok, result, bcnt);
    end
    tick();
    start = 1'b1; op = 2'b00; a = 32'h0000_0001; shamt = 5'd10;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_shift: busy=%b done=%b result=%h, required 0 0 00000000",
               busy, done, result);
    end
    saw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) saw = 1'b1;
      tick();
    end
    checks++;
    if (saw) begin
      errors++;
      $display("FAIL reset_no_done: activity=1, required 0");
    end
  endtask

  initial begin
    test_reset();
    test_sra();
    test_full_width();
    test_zero_and_reserved();
    test_back_to_back();
    test_flush();
    test_busy_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
